// File: rtl/mm_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mm_seq_pkg
//  Description : Shared types and helpers for the modular-multiplier operand
//                sequencer. The TX state is present only when MM_RESULT_TX_EN
//                is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
package mm_seq_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        LOAD_X = 3'd0,
        LOAD_Y = 3'd1,
        ISSUE  = 3'd2,
`ifdef MM_RESULT_TX_EN
        WAIT   = 3'd3,
        TX     = 3'd4
`else
        WAIT   = 3'd3
`endif
    } state_t;

    // Number of bytes needed to carry a width-bit word
    function automatic int bytes_of(input int width);
        return width / BYTE_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mm_byte_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : mm_byte_serializer
//  Description : Streams a WIDTH-bit word out LSB byte first over a
//                valid/ready handshake. Started by a one-cycle pulse while the
//                word is stable; done is a combinational strobe in the cycle
//                the last byte transfers.
//  Revision    : 1.0 - initial release
// ============================================================================
module mm_byte_serializer
    import mm_seq_pkg::*;
#(
    parameter int WIDTH = 256
) (
    input  logic             clock,
    input  logic             reset_all,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    input  logic             tx_ready,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    output logic             done
);

    localparam int NB = bytes_of(WIDTH);
    localparam int CW = $clog2(NB);
    localparam logic [CW-1:0] LAST_BYTE = CW'(NB - 1);

    logic [CW-1:0] idx;
    logic [CW-1:0] next_idx;

    assign next_idx = idx + CW'(1);
    assign done     = tx_valid && tx_ready && (idx == LAST_BYTE);

    // Present byte idx of data; advance on each accepted transfer
    always_ff @(posedge clock or negedge reset_all) begin
        if (!reset_all) begin
            idx      <= '0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
        end else if (start) begin
            idx      <= '0;
            tx_valid <= 1'b1;
            tx_data  <= data[BYTE_W-1:0];
        end else if (tx_valid && tx_ready) begin
            if (idx == LAST_BYTE) begin
                idx      <= '0;
                tx_valid <= 1'b0;
            end else begin
                idx     <= next_idx;
                tx_data <= data[next_idx*BYTE_W +: BYTE_W];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mm_operand_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mm_operand_sequencer
//  Description : Assembles operands X and Y from an LSB-first byte stream,
//                issues a one-cycle start pulse to the multiplier, waits for
//                the result with a timeout and captures Q. With
//                MM_RESULT_TX_EN defined, Q is streamed back out as bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
module mm_operand_sequencer
    import mm_seq_pkg::*;
#(
    parameter int WIDTH   = 256,
    parameter int TIMEOUT = 4096
) (
    input  logic             clock,
    input  logic             reset_all,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    input  logic             err_clr,
`ifdef MM_RESULT_TX_EN
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
`endif
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic             mul_in_valid,
    input  logic             mul_out_valid,
    input  logic [WIDTH-1:0] mul_q,
    output logic [WIDTH-1:0] q,
    output logic             res_valid,
    output logic             busy,
    output logic             err_timeout,
    output logic             err_overrun
);

    localparam int NB = bytes_of(WIDTH);
    localparam int CW = $clog2(NB);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_BYTE = CW'(NB - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(TIMEOUT - 1);

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] byte_cnt;
    logic [TW-1:0] tick_cnt;
    logic          load_x;
    logic          load_y;
    logic          capture;
    logic          timeout_evt;
    logic          overrun_evt;
    logic          last_byte;

    assign last_byte = (byte_cnt == LAST_BYTE);

`ifdef MM_RESULT_TX_EN
    logic ser_done;

    mm_byte_serializer #(
        .WIDTH (WIDTH)
    ) u_serializer (
        .clock     (clock),
        .reset_all (reset_all),
        .start     (res_valid),
        .data      (q),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .done      (ser_done)
    );
`endif

    // Next-state and per-cycle event decode
    always_comb begin
        next_state  = state;
        load_x      = 1'b0;
        load_y      = 1'b0;
        capture     = 1'b0;
        timeout_evt = 1'b0;
        overrun_evt = 1'b0;
        case (state)
            LOAD_X: begin
                if (rx_valid) begin
                    load_x = 1'b1;
                    if (last_byte) next_state = LOAD_Y;
                end
            end
            LOAD_Y: begin
                if (rx_valid) begin
                    load_y = 1'b1;
                    if (last_byte) next_state = ISSUE;
                end
            end
            ISSUE: begin
                overrun_evt = rx_valid;
                next_state  = WAIT;
            end
            WAIT: begin
                overrun_evt = rx_valid;
                // A result arriving on the final tick beats the timeout
                if (mul_out_valid) begin
                    capture = 1'b1;
`ifdef MM_RESULT_TX_EN
                    next_state = TX;
`else
                    next_state = LOAD_X;
`endif
                end else if (tick_cnt == LAST_TICK) begin
                    timeout_evt = 1'b1;
                    next_state  = LOAD_X;
                end
            end
`ifdef MM_RESULT_TX_EN
            TX: begin
                overrun_evt = rx_valid;
                if (ser_done) next_state = LOAD_X;
            end
`endif
            default: next_state = LOAD_X;
        endcase
    end

    // State, counters, operand/result registers and registered outputs
    always_ff @(posedge clock or negedge reset_all) begin
        if (!reset_all) begin
            state        <= LOAD_X;
            byte_cnt     <= '0;
            tick_cnt     <= '0;
            x            <= '0;
            y            <= '0;
            q            <= '0;
            mul_in_valid <= 1'b0;
            res_valid    <= 1'b0;
            busy         <= 1'b0;
            err_timeout  <= 1'b0;
            err_overrun  <= 1'b0;
        end else begin
            state        <= next_state;
            mul_in_valid <= (next_state == ISSUE);
            busy         <= (next_state != LOAD_X) && (next_state != LOAD_Y);
            res_valid    <= capture;

            if (load_x || load_y) begin
                byte_cnt <= last_byte ? '0 : byte_cnt + CW'(1);
            end
            if (load_x) x[byte_cnt*BYTE_W +: BYTE_W] <= rx_data;
            if (load_y) y[byte_cnt*BYTE_W +: BYTE_W] <= rx_data;

            if (state == ISSUE) begin
                tick_cnt <= '0;
            end else if (state == WAIT && !capture && !timeout_evt) begin
                tick_cnt <= tick_cnt + TW'(1);
            end

            if (capture) q <= mul_q;

            // Set has priority over clear on both sticky flags
            if (timeout_evt)  err_timeout <= 1'b1;
            else if (err_clr) err_timeout <= 1'b0;
            if (overrun_evt)  err_overrun <= 1'b1;
            else if (err_clr) err_overrun <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mm_operand_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mm_operand_sequencer
//  Description : Directed self-checking bench for mm_operand_sequencer at
//                WIDTH=16, TIMEOUT=8. Result-TX checks appear when
//                MM_RESULT_TX_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mm_operand_sequencer;

    localparam int WIDTH   = 16;
    localparam int TIMEOUT = 8;

    logic             clock = 1'b0;
    logic             reset_all;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             err_clr;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             mul_in_valid;
    logic             mul_out_valid;
    logic [WIDTH-1:0] mul_q;
    logic [WIDTH-1:0] q;
    logic             res_valid;
    logic             busy;
    logic             err_timeout;
    logic             err_overrun;
`ifdef MM_RESULT_TX_EN
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
`endif

    int n_cmp = 0;
    int n_err = 0;

    mm_operand_sequencer #(
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock         (clock),
        .reset_all     (reset_all),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .err_clr       (err_clr),
`ifdef MM_RESULT_TX_EN
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
`endif
        .x             (x),
        .y             (y),
        .mul_in_valid  (mul_in_valid),
        .mul_out_valid (mul_out_valid),
        .mul_q         (mul_q),
        .q             (q),
        .res_valid     (res_valid),
        .busy          (busy),
        .err_timeout   (err_timeout),
        .err_overrun   (err_overrun)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    // Return the multiplier result in the current cycle
    task automatic give_result(input logic [WIDTH-1:0] v);
        mul_q         = v;
        mul_out_valid = 1'b1;
        tick();
        mul_out_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            tick();
        end
        check("idle_reached", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        reset_all     = 1'b0;
        rx_data       = 8'h00;
        rx_valid      = 1'b0;
        err_clr       = 1'b0;
        mul_out_valid = 1'b0;
        mul_q         = '0;
`ifdef MM_RESULT_TX_EN
        tx_ready      = 1'b0;
`endif
        tick();
        tick();

        // Reset state
        check("rst_x", 32'(x), 32'h0);
        check("rst_y", 32'(y), 32'h0);
        check("rst_q", 32'(q), 32'h0);
        check("rst_flags", {27'd0, mul_in_valid, res_valid, busy, err_timeout, err_overrun}, 32'h0);
`ifdef MM_RESULT_TX_EN
        check("rst_tx", {23'd0, tx_valid, tx_data}, 32'h0);
`endif
        reset_all = 1'b1;
        tick();

        // Op 1: load, start pulse, result three cycles after the pulse
        send_byte(8'h34);
        send_byte(8'h12);
        send_byte(8'h78);
        check("op1_no_early_start", {31'd0, mul_in_valid}, 32'd0);
        send_byte(8'h56);
        check("op1_x", 32'(x), 32'h1234);
        check("op1_y", 32'(y), 32'h5678);
        check("op1_start", {31'd0, mul_in_valid}, 32'd1);
        check("op1_busy", {31'd0, busy}, 32'd1);
        tick();
        check("op1_start_single", {31'd0, mul_in_valid}, 32'd0);
        tick();
        tick();
        give_result(16'hBEEF);
        check("op1_q", 32'(q), 32'hBEEF);
        check("op1_res_valid", {31'd0, res_valid}, 32'd1);
`ifdef MM_RESULT_TX_EN
        // tx_ready low for 5 cycles, then high
        for (int i = 0; i < 5; i++) begin
            tick();
            check("tx_stall_valid", {31'd0, tx_valid}, 32'd1);
            check("tx_stall_byte0", 32'(tx_data), 32'hEF);
        end
        tx_ready = 1'b1;
        tick();
        check("tx_byte1", 32'(tx_data), 32'hBE);
        check("tx_byte1_valid", {31'd0, tx_valid}, 32'd1);
        tick();
        check("tx_done_valid", {31'd0, tx_valid}, 32'd0);
        check("tx_done_idle", {31'd0, busy}, 32'd0);
`else
        tick();
        check("op1_res_pulse", {31'd0, res_valid}, 32'd0);
`endif
        check("op1_q_hold", 32'(q), 32'hBEEF);
        wait_idle();

        // Op 2: no result -> timeout after TIMEOUT cycles in WAIT
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        check("op2_x", 32'(x), 32'h0201);
        check("op2_y", 32'(y), 32'h0403);
        check("op2_start", {31'd0, mul_in_valid}, 32'd1);
        tick();
        repeat (TIMEOUT - 1) tick();
        check("op2_no_early_timeout", {30'd0, err_timeout, busy}, 32'd1);
        tick();
        check("op2_timeout", {31'd0, err_timeout}, 32'd1);
        check("op2_idle", {31'd0, busy}, 32'd0);
        check("op2_q_unchanged", 32'(q), 32'hBEEF);
        check("op2_no_res", {31'd0, res_valid}, 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("op2_err_clr", {31'd0, err_timeout}, 32'd0);

        // Op 3: byte during WAIT (with err_clr same cycle) -> overrun set
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_byte(8'hDD);
        tick();
        err_clr = 1'b1;
        send_byte(8'h55);
        err_clr = 1'b0;
        check("op3_overrun", {31'd0, err_overrun}, 32'd1);
        check("op3_x_kept", 32'(x), 32'hBBAA);
        check("op3_y_kept", 32'(y), 32'hDDCC);
        give_result(16'h1357);
        check("op3_q", 32'(q), 32'h1357);
        wait_idle();

        // Op 4: loads correctly after overrun; result on the final tick wins
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        check("op4_x", 32'(x), 32'h2211);
        check("op4_y", 32'(y), 32'h4433);
        tick();
        repeat (TIMEOUT - 1) tick();
        give_result(16'hCAFE);
        check("op4_q_last_tick", 32'(q), 32'hCAFE);
        check("op4_res_valid", {31'd0, res_valid}, 32'd1);
        check("op4_no_timeout", {31'd0, err_timeout}, 32'd0);
        check("op4_overrun_sticky", {31'd0, err_overrun}, 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("op4_overrun_clr", {31'd0, err_overrun}, 32'd0);
        wait_idle();

        // Reset after one byte of y, then a fresh load
        send_byte(8'hA1);
        send_byte(8'hA2);
        send_byte(8'hA3);
        reset_all = 1'b0;
        #2;
        check("mid_rst_x", 32'(x), 32'h0);
        check("mid_rst_y", 32'(y), 32'h0);
        check("mid_rst_q", 32'(q), 32'h0);
        check("mid_rst_flags", {27'd0, mul_in_valid, res_valid, busy, err_timeout, err_overrun}, 32'h0);
        tick();
        reset_all = 1'b1;
        tick();
        send_byte(8'h21);
        send_byte(8'h43);
        send_byte(8'h65);
        send_byte(8'h87);
        check("op5_x", 32'(x), 32'h4321);
        check("op5_y", 32'(y), 32'h8765);
        check("op5_start", {31'd0, mul_in_valid}, 32'd1);
        tick();
        give_result(16'h0F0F);
        check("op5_q", 32'(q), 32'h0F0F);
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mm_operand_sequencer.md
# mm_operand_sequencer

Byte-stream front end and control sequencer for the modular multiplier. Assembles two WIDTH-bit operands X and Y from the UART receiver's byte stream and issues a single-cycle start pulse to the multiplier core. It then waits for the result with a timeout, captures Q, and optionally streams Q back out as bytes. The block sits between the UART receive path and the multiplier core, replacing the sticky start flag of the previous top level with a repeatable, per-operation handshake.

## Interface
- WIDTH, 256, operand/result width in bits; must be a multiple of 8 and at least 16
- TIMEOUT, 4096, maximum cycles to wait for mul_out_valid before aborting; must be at least 1
- clock  in  1  single clock, all logic rising-edge
- reset_all  in  1  asynchronous, active-low reset
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data valid this cycle; no backpressure
- err_clr  in  1  clears both sticky error flags
- x, y  out  WIDTH  assembled operands, held stable from ISSUE until the next load overwrites them
- mul_in_valid  out  1  one-cycle start pulse to the multiplier
- mul_out_valid  in  1  multiplier result valid
- mul_q  in  WIDTH  multiplier result
- q  out  WIDTH  captured result, held until the next capture
- res_valid  out  1  one-cycle pulse in the cycle q updates
- busy  out  1  high in ISSUE, WAIT and TX
- err_timeout, err_overrun  out  1  sticky error flags
- tx_data  out  8  result byte (present only with MM_RESULT_TX_EN)
- tx_valid  out  1  tx_data valid (present only with MM_RESULT_TX_EN)
- tx_ready  in  1  downstream accepts the byte (present only with MM_RESULT_TX_EN)

## Operation
- Let NB = WIDTH/8. Byte counter width is $clog2(NB).
- Bytes arrive LSB-first. Byte k is written to bits [8k+7:8k].
- States are LOAD_X, LOAD_Y, ISSUE, WAIT and TX (TX exists only with the macro).
- LOAD_X: each rx_valid writes one byte of x. After byte NB-1: clear the counter and go to LOAD_Y.
- LOAD_Y: each rx_valid writes one byte of y in the same way. After byte NB-1: go to ISSUE.
- ISSUE: mul_in_valid=1 for exactly one cycle, then go to WAIT. The timeout counter clears here.
- WAIT, on mul_out_valid: capture mul_q into q, pulse res_valid, then go to TX (macro) or LOAD_X (no macro).
- WAIT, on timeout: if the counter reaches TIMEOUT-1 with no mul_out_valid, set err_timeout, go to LOAD_X, and leave q unchanged.
- If mul_out_valid and the timeout occur in the same cycle, the result wins and err_timeout is not set.
- mul_out_valid is ignored in every state except WAIT.
- rx_valid in ISSUE, WAIT or TX drops the byte and sets err_overrun.
- err_clr clears both flags. If err_clr and a new error event occur in the same cycle, the flag is set (set wins).
- Reset values: state=LOAD_X, counters=0, x=y=q=0, and all 1-bit outputs 0 (tx_data=0 with the macro).

## Timing
- The last byte of y accepted at cycle t produces mul_in_valid=1 at t+1.
- mul_out_valid at cycle w produces q updated and res_valid=1 at w+1.
- The earliest next x byte is accepted at w+1 without the macro, or one cycle after the last TX handshake with it.
- All outputs are registered. There is no combinational path from any input to any output.
- Reset asserted mid-operation returns to LOAD_X immediately and discards any partial operands. It does not report an error.

## Configuration
- MM_RESULT_TX_EN defined:
  - TX state and tx_* ports exist.
  - tx_valid rises in the cycle after capture and holds with byte k=0 of q.
  - A byte transfers on tx_valid&&tx_ready, and the next byte is presented the following cycle.
  - After byte NB-1 transfers, tx_valid drops and the state returns to LOAD_X.
  - A tx_ready held low stalls indefinitely (no timeout in TX).
- MM_RESULT_TX_EN undefined: no tx_* ports and no TX state. Capture goes directly to LOAD_X.

## Structure
- Package mm_seq_pkg holds:
  - the state enum;
  - BYTE_W=8;
  - a function bytes_of(width) returning width/8.
- Sub-module mm_byte_serializer holds the TX byte counter and handshake, parameterised by WIDTH. It is instantiated only under MM_RESULT_TX_EN.
- Byte assembly and the FSM stay in the top file.

## Test plan
- WIDTH=16: send bytes 0x34,0x12,0x78,0x56 -> x=0x1234, y=0x5678, and mul_in_valid is a single pulse one cycle after the 4th byte.
- Model returns mul_q=0xBEEF three cycles after the start pulse -> q=0xBEEF and res_valid pulses for one cycle. A second operand pair produces a second start pulse.
- TIMEOUT=8 with no mul_out_valid -> err_timeout=1 exactly 8 cycles into WAIT, state is LOAD_X, q is unchanged. Then err_clr -> err_timeout=0.
- Byte sent during WAIT -> err_overrun=1, x and y unchanged, and the next operation loads correctly.
- reset_all pulled low after 1 byte of y -> all outputs 0, and a fresh 4-byte load succeeds.
- With MM_RESULT_TX_EN, q=0xBEEF and tx_ready low for 5 cycles then high -> tx_data sequence 0xEF then 0xBE, tx_valid held stable during the stall, then back to LOAD_X.
